// File: rtl/mbox_rx_if.sv
// mbox_rx_if: WISHBONE slave that pulls bytes from an inbound mailbox FIFO,
// packs four of them little-endian into a 32-bit word and hands the word out
// through the MBOX_IBUF register. Also exposes status, a flush control bit
// and a running count of words consumed.
module mbox_rx_if #(
    parameter int WB_AW  = 6,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [WB_AW-1:2]  wb_adr_i,
    input  logic [WB_DW-1:0]  wb_dat_i,
    output logic [WB_DW-1:0]  wb_dat_o,
    output logic              wb_ack_o,
    output logic              mbox_rd_o,
    input  logic              mbox_empty_i,
    input  logic [WOU_DW-1:0] mbox_di_i
);

    localparam int ADR_W = WB_AW - 2;
    localparam int ASM_W = 4 * WOU_DW;

    localparam logic [ADR_W-1:0] ADR_IBUF = ADR_W'(32'd0);
    localparam logic [ADR_W-1:0] ADR_STAT = ADR_W'(32'd1);
    localparam logic [ADR_W-1:0] ADR_CTRL = ADR_W'(32'd2);
    localparam logic [ADR_W-1:0] ADR_WCNT = ADR_W'(32'd3);

    typedef enum logic [1:0] {
        FILL_RD  = 2'd0,
        FILL_CAP = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       byte_cnt_r;
    logic             word_valid_r;
    logic [ASM_W-1:0] asm_r;
    logic [31:0]      wcnt_r;

    logic             bus_req_s;
    logic             ibuf_rd_sel_s;
    logic             ack_nxt_s;
    logic             ibuf_ack_s;
    logic             rd_ack_s;
    logic             flush_s;
    logic             pop_s;
    logic             cap_s;
    logic [31:0]      stat_s;
    logic [WB_DW-1:0] rd_data_s;
    logic             unused_s;

    // Only bit 0 of the byte selects and write data carries meaning (flush).
    assign unused_s = ^{wb_sel_i[3:1], wb_dat_i[WB_DW-1:1]};

    // Bus decode: acknowledge generation, IBUF consume and flush strobes.
    always_comb begin
        bus_req_s     = wb_cyc_i & wb_stb_i;
        ibuf_rd_sel_s = bus_req_s & ~wb_we_i & (wb_adr_i == ADR_IBUF);
        // An IBUF read with no word ready is held off (no ack) until one is.
        ack_nxt_s     = bus_req_s & ~wb_ack_o & ~(ibuf_rd_sel_s & ~word_valid_r);
        ibuf_ack_s    = ack_nxt_s & ibuf_rd_sel_s;
        rd_ack_s      = ack_nxt_s & ~wb_we_i;
        flush_s       = ack_nxt_s & wb_we_i & (wb_adr_i == ADR_CTRL)
                        & wb_sel_i[0] & wb_dat_i[0];
    end

    // Status word as seen by software.
    always_comb begin
        stat_s = {29'd0, (byte_cnt_r != 2'd0), word_valid_r, mbox_empty_i};
    end

    // Read data mux; unmapped addresses return zero.
    always_comb begin
        rd_data_s = {WB_DW{1'b0}};
        case (wb_adr_i)
            ADR_IBUF: rd_data_s = WB_DW'(asm_r);
            ADR_STAT: rd_data_s = WB_DW'(stat_s);
            ADR_CTRL: rd_data_s = {WB_DW{1'b0}};
            ADR_WCNT: rd_data_s = WB_DW'(wcnt_r);
            default:  rd_data_s = {WB_DW{1'b0}};
        endcase
    end

    // Fill FSM next state: one pop, one capture, repeat four times, then hold.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        cap_s       = 1'b0;
        if (flush_s) begin
            // Flush wins over everything, including a pending capture; the
            // byte already popped from the FIFO is dropped on purpose.
            state_nxt_s = FILL_RD;
        end else begin
            case (state_r)
                FILL_RD: begin
                    if (!mbox_empty_i) begin
                        pop_s       = 1'b1;
                        state_nxt_s = FILL_CAP;
                    end else begin
                        state_nxt_s = FILL_RD;
                    end
                end
                FILL_CAP: begin
                    cap_s = 1'b1;
                    if (byte_cnt_r == 2'd3) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = FILL_RD;
                    end
                end
                HOLD: begin
                    if (ibuf_ack_s) begin
                        state_nxt_s = FILL_RD;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s = FILL_RD;
                end
            endcase
        end
    end

    // The pop must reach the FIFO in the same cycle the FSM leaves FILL_RD so
    // that its byte is on mbox_di_i during FILL_CAP; reset blocks it.
    assign mbox_rd_o = pop_s & ~wb_rst_i;

    // FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= FILL_RD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word assembly: byte lane capture, byte counter and word-valid flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            byte_cnt_r   <= 2'd0;
            word_valid_r <= 1'b0;
            asm_r        <= {ASM_W{1'b0}};
        end else if (flush_s) begin
            byte_cnt_r   <= 2'd0;
            word_valid_r <= 1'b0;
            asm_r        <= {ASM_W{1'b0}};
        end else begin
            if (cap_s) begin
                case (byte_cnt_r)
                    2'd0:    asm_r[WOU_DW-1:0]          <= mbox_di_i;
                    2'd1:    asm_r[2*WOU_DW-1:WOU_DW]   <= mbox_di_i;
                    2'd2:    asm_r[3*WOU_DW-1:2*WOU_DW] <= mbox_di_i;
                    2'd3:    asm_r[4*WOU_DW-1:3*WOU_DW] <= mbox_di_i;
                    default: asm_r                      <= asm_r;
                endcase
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
            if (cap_s && (byte_cnt_r == 2'd3)) begin
                word_valid_r <= 1'b1;
            end else if (ibuf_ack_s) begin
                word_valid_r <= 1'b0;
            end else begin
                word_valid_r <= word_valid_r;
            end
        end
    end

    // Consumed-word counter, wraps naturally at 32 bits; flush leaves it alone.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wcnt_r <= 32'd0;
        end else if (ibuf_ack_s) begin
            wcnt_r <= wcnt_r + 32'd1;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Registered bus response: ack one cycle after strobe, data with it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= {WB_DW{1'b0}};
        end else begin
            wb_ack_o <= ack_nxt_s;
            if (rd_ack_s) begin
                wb_dat_o <= rd_data_s;
            end else begin
                wb_dat_o <= wb_dat_o;
            end
        end
    end

endmodule

// File: tb/tb_mbox_rx_if.sv
// Self-checking bench for mbox_rx_if: a queue-based mailbox FIFO model feeds
// the DUT, and a byte-stream reference model predicts every word, status and
// counter value the bus reads should return.
module tb_mbox_rx_if;

    localparam int WB_AW  = 6;
    localparam int WB_DW  = 32;
    localparam int WOU_DW = 8;

    localparam logic [3:0] A_IBUF = 4'h0;
    localparam logic [3:0] A_STAT = 4'h1;
    localparam logic [3:0] A_CTRL = 4'h2;
    localparam logic [3:0] A_WCNT = 4'h3;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [WB_AW-1:2]  wb_adr_i;
    logic [WB_DW-1:0]  wb_dat_i;
    logic [WB_DW-1:0]  wb_dat_o;
    logic              wb_ack_o;
    logic              mbox_rd_o;
    logic              mbox_empty_i;
    logic [WOU_DW-1:0] mbox_di_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rd_pulses = 0;
    logic        prev_rd = 1'b0;
    logic        pend_vld = 1'b0;
    logic [7:0]  pend_byte = 8'd0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  model_q[$];
    logic [31:0] wcnt_m = 32'd0;

    mbox_rx_if #(.WB_AW(WB_AW), .WB_DW(WB_DW), .WOU_DW(WOU_DW)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_we_i      (wb_we_i),
        .wb_sel_i     (wb_sel_i),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .mbox_rd_o    (mbox_rd_o),
        .mbox_empty_i (mbox_empty_i),
        .mbox_di_i    (mbox_di_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // FIFO model, pop side: sample the pop request mid-cycle.
    always @(negedge wb_clk_i) begin
        if (mbox_rd_o === 1'b1) begin
            rd_pulses++;
            check_eq("rd_back_to_back", {31'd0, prev_rd}, 32'd0);
            check_eq("rd_while_empty", {31'd0, (fifo_q.size() == 0)}, 32'd0);
            if (fifo_q.size() > 0) begin
                pend_byte = fifo_q.pop_front();
                pend_vld  = 1'b1;
            end
        end
        prev_rd = mbox_rd_o;
    end

    // FIFO model, output side: popped byte appears after the pop edge.
    always begin
        @(posedge wb_clk_i);
        #2;
        if (pend_vld) begin
            mbox_di_i = pend_byte;
            pend_vld  = 1'b0;
        end else begin
            mbox_di_i = 8'($urandom);
        end
        mbox_empty_i = (fifo_q.size() == 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        model_q.push_back(b);
    endtask

    task automatic drop(input int n);
        logic [7:0] t;
        for (int i = 0; i < n; i++) begin
            t = model_q.pop_front();
        end
    endtask

    function automatic logic [31:0] pop_word();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = model_q.pop_front();
        end
        return w;
    endfunction

    // Expected STAT after the DUT has settled, from the unconsumed byte count.
    function automatic logic [31:0] stat_exp();
        int s;
        s = model_q.size();
        return {29'd0, (s > 0 && s < 4), (s >= 4), (s <= 4)};
    endfunction

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input int budget,
                           output logic [31:0] rdat, output logic acked, output int cycles);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = wdat;
        acked    = 1'b0;
        rdat     = 32'd0;
        cycles   = 0;
        while (!acked && cycles < budget) begin
            tick();
            cycles++;
            if (wb_ack_o === 1'b1) begin
                acked = 1'b1;
                rdat  = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] adr, input int budget, input string tag,
                            input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        int          c;
        wb_xfer(1'b0, adr, 4'hF, 32'd0, budget, d, a, c);
        check_eq({tag, "_ack"}, {31'd0, a}, 32'd1);
        check_eq(tag, d, exp);
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [3:0] sel,
                             input logic [31:0] wdat, input string tag);
        logic [31:0] d;
        logic        a;
        int          c;
        wb_xfer(1'b1, adr, sel, wdat, 10, d, a, c);
        check_eq({tag, "_ack"}, {31'd0, a}, 32'd1);
    endtask

    task automatic ibuf_read(input string tag, input int budget);
        logic [31:0] e;
        e = pop_word();
        wcnt_m = wcnt_m + 32'd1;
        bus_read(A_IBUF, budget, tag, e);
    endtask

    initial begin
        logic [31:0] d;
        logic        a;
        int          c;
        int          r0;
        int          s;
        logic        seen;

        wb_rst_i     = 1'b1;
        wb_cyc_i     = 1'b0;
        wb_stb_i     = 1'b0;
        wb_we_i      = 1'b0;
        wb_sel_i     = 4'h0;
        wb_adr_i     = 4'h0;
        wb_dat_i     = 32'd0;
        mbox_empty_i = 1'b1;
        mbox_di_i    = 8'd0;
        repeat (3) tick();
        check_eq("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        check_eq("rst_rd", {31'd0, mbox_rd_o}, 32'd0);
        wb_rst_i = 1'b0;
        tick();

        // Reset state, single-cycle read latency.
        wb_xfer(1'b0, A_STAT, 4'hF, 32'd0, 10, d, a, c);
        check_eq("stat_rst", d, 32'd1);
        check_eq("read_latency", c, 32'd1);
        bus_read(A_WCNT, 10, "wcnt_rst", 32'd0);
        bus_read(A_CTRL, 10, "ctrl_read", 32'd0);

        // Preloaded 0x11..0x44 -> one little-endian word.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        drop(4);
        wcnt_m = wcnt_m + 32'd1;
        bus_read(A_IBUF, 40, "s1_word", 32'h4433_2211);
        bus_read(A_STAT, 10, "s1_stat", 32'd1);
        bus_read(A_WCNT, 10, "s1_wcnt", 32'd1);

        // IBUF read stalls on an empty mailbox; bytes arrive 20 cycles later.
        r0 = rd_pulses;
        fork
            wb_xfer(1'b0, A_IBUF, 4'hF, 32'd0, 80, d, a, c);
            begin
                repeat (20) tick();
                for (int i = 0; i < 4; i++) push(8'($urandom));
            end
        join
        wcnt_m = wcnt_m + 32'd1;
        check_eq("s2_ack", {31'd0, a}, 32'd1);
        check_eq("s2_word", d, pop_word());
        check_eq("s2_no_early_ack", {31'd0, (c >= 29)}, 32'd1);
        check_eq("s2_pops", rd_pulses - r0, 32'd4);

        // Eight bytes waiting, no reads: four pops, then hold.
        r0 = rd_pulses;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        repeat (30) tick();
        check_eq("s3_pops", rd_pulses - r0, 32'd4);
        check_eq("s3_fifo_left", fifo_q.size(), 32'd4);
        bus_read(A_STAT, 10, "s3_stat", 32'd2);
        ibuf_read("s3_word1", 40);
        ibuf_read("s3_word2", 40);
        bus_read(A_WCNT, 10, "s3_wcnt", wcnt_m);

        // Flush with two bytes captured.
        push(8'($urandom)); push(8'($urandom));
        repeat (10) tick();
        bus_read(A_STAT, 10, "s4_stat_pre", 32'd5);
        bus_write(A_CTRL, 4'hF, 32'd1, "s4_flush");
        drop(2);
        bus_read(A_STAT, 10, "s4_stat_post", 32'd1);
        bus_read(A_WCNT, 10, "s4_wcnt", wcnt_m);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        ibuf_read("s4_word", 40);

        // Flush landing on the capture edge of the second byte.
        push(8'($urandom));
        repeat (6) tick();
        push(8'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge wb_clk_i);
            seen = mbox_rd_o;
        end
        check_eq("s5_pop_seen", {31'd0, seen}, 32'd1);
        @(posedge wb_clk_i);
        #1;
        wb_xfer(1'b1, A_CTRL, 4'hF, 32'd1, 10, d, a, c);
        check_eq("s5_flush_on_cap", c, 32'd1);
        drop(2);
        bus_read(A_STAT, 10, "s5_stat", 32'd1);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        ibuf_read("s5_word", 40);

        // WCNT wrap from all-ones.
        force dut.wcnt_r = 32'hFFFF_FFFF;
        tick();
        release dut.wcnt_r;
        wcnt_m = 32'hFFFF_FFFF;
        bus_read(A_WCNT, 10, "s6_wcnt_pre", 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        ibuf_read("s6_word", 40);
        bus_read(A_WCNT, 10, "s6_wcnt_wrap", 32'd0);

        // Reset with three bytes captured and more waiting in the FIFO.
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (10) tick();
        bus_read(A_STAT, 10, "s7_stat_pre", 32'd5);
        push(8'($urandom)); push(8'($urandom));
        wb_rst_i = 1'b1;
        tick();
        @(negedge wb_clk_i);
        check_eq("s7_rst_rd", {31'd0, mbox_rd_o}, 32'd0);
        tick();
        check_eq("s7_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check_eq("s7_rst_dat", wb_dat_o, 32'd0);
        wb_rst_i = 1'b0;
        drop(3);
        wcnt_m = 32'd0;
        bus_read(A_WCNT, 10, "s7_wcnt", 32'd0);
        push(8'($urandom)); push(8'($urandom));
        ibuf_read("s7_word", 40);

        // Randomized traffic against the byte-stream model.
        for (int it = 0; it < 30; it++) begin
            s = $urandom_range(0, 5);
            for (int i = 0; i < s; i++) push(8'($urandom));
            repeat (12) tick();
            case ($urandom_range(0, 5))
                0: begin
                    if (model_q.size() >= 4) ibuf_read("rnd_word", 20);
                    else bus_read(A_STAT, 10, "rnd_stat0", stat_exp());
                end
                1: bus_read(A_STAT, 10, "rnd_stat", stat_exp());
                2: begin
                    bus_read(A_WCNT, 10, "rnd_wcnt", wcnt_m);
                    wb_xfer(1'b0, 4'h5, 4'hF, 32'd0, 10, d, a, c);
                    check_eq("rnd_unmapped_ack", {31'd0, a}, 32'd1);
                end
                3: begin
                    case ($urandom_range(0, 2))
                        0: bus_write(A_IBUF, 4'hF, $urandom, "rnd_wr_ibuf");
                        1: bus_write(A_STAT, 4'hF, $urandom, "rnd_wr_stat");
                        default: bus_write(A_WCNT, 4'hF, $urandom, "rnd_wr_wcnt");
                    endcase
                    bus_read(A_WCNT, 10, "rnd_wcnt_after_wr", wcnt_m);
                    bus_read(A_STAT, 10, "rnd_stat_after_wr", stat_exp());
                end
                4: begin
                    if ($urandom_range(0, 1) == 0) bus_write(A_CTRL, 4'hE, 32'hFFFF_FFFF, "rnd_ctrl_nosel");
                    else bus_write(A_CTRL, 4'hF, 32'hFFFF_FFFE, "rnd_ctrl_nobit");
                    bus_read(A_STAT, 10, "rnd_stat_noflush", stat_exp());
                end
                default: begin
                    s = model_q.size();
                    bus_write(A_CTRL, 4'hF, 32'd1, "rnd_flush");
                    drop((s >= 4) ? 4 : s);
                end
            endcase
        end
        repeat (12) tick();
        bus_read(A_WCNT, 10, "final_wcnt", wcnt_m);
        bus_read(A_STAT, 10, "final_stat", stat_exp());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
